// File: rtl/router_pkg.sv
// Shared types and header/parity helpers for the 1-to-N packet router.
package router_pkg;

    // Helpers work on a wide vector so they serve every DATA_W up to MAX_W.
    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HDR,
        ST_LOAD_DATA,
        ST_LOAD_PARITY,
        ST_CHECK,
        ST_DROP
    } state_t;

    function automatic int unsigned addr_width(input int unsigned n_ports);
        return (n_ports < 2) ? 1 : $clog2(n_ports);
    endfunction

    function automatic logic [MAX_W-1:0] hdr_addr(input logic [MAX_W-1:0] hdr, input int unsigned aw);
        return hdr & ((MAX_W'(1) << aw) - MAX_W'(1));
    endfunction

    function automatic logic [MAX_W-1:0] hdr_len(input logic [MAX_W-1:0] hdr, input int unsigned aw);
        return hdr >> aw;
    endfunction

    function automatic logic [MAX_W-1:0] parity_acc(input logic [MAX_W-1:0] acc, input logic [MAX_W-1:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/router_if.sv
// Source byte stream and per-destination read ports of the router.
interface router_if #(
    parameter int N_PORTS = 3,
    parameter int DATA_W  = 8
);
    logic                      pkt_valid;
    logic [DATA_W-1:0]         data_in;
    logic                      busy;
    logic                      error;
    logic [N_PORTS-1:0]        read_enb;
    logic [N_PORTS-1:0]        valid_out;
    logic [N_PORTS*DATA_W-1:0] data_out;

    modport master (
        output pkt_valid, data_in, read_enb,
        input  busy, error, valid_out, data_out
    );

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output busy, error, valid_out, data_out
    );
endinterface

// File: rtl/router_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head reads as 0 when empty.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/router_1xn.sv
// 1-to-N packet router: header decode, per-port FIFOs, parity check, backpressure.
// Optional ROUTER_SOFT_RESET_EN: flush a destination FIFO its reader leaves idle for TIMEOUT cycles.
module router_1xn
    import router_pkg::*;
#(
    parameter int N_PORTS    = 3,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input logic      clock,
    input logic      resetn,
    router_if.slave  bus
);
    localparam int ADDR_W = addr_width(N_PORTS);

    state_t                    state_reg;
    logic [DATA_W-1:0]         hdr_reg;
    logic [DATA_W-1:0]         cnt_reg;
    logic [DATA_W-1:0]         par_reg;
    logic [DATA_W-1:0]         rx_par_reg;
    logic                      error_reg;

    logic [ADDR_W-1:0]         addr;
    logic                      busy;
    logic                      accept;
    logic                      write_en;
    logic                      target_flushed;
    logic [DATA_W-1:0]         push_data;
    logic [N_PORTS-1:0]        empty;
    logic [N_PORTS-1:0]        full;
    logic [N_PORTS-1:0]        push;
    logic [N_PORTS-1:0]        flush;
    logic [N_PORTS-1:0]        valid;
    logic [N_PORTS*DATA_W-1:0] dout;

    assign addr = ADDR_W'(hdr_addr(MAX_W'(hdr_reg), ADDR_W));

    always_comb begin
        busy = 1'b0;
        case (state_reg)
            ST_LOAD_HDR, ST_CHECK:        busy = 1'b1;
            ST_LOAD_DATA, ST_LOAD_PARITY: busy = full[addr];
            default:                      busy = 1'b0;
        endcase
    end

    assign accept    = bus.pkt_valid && !busy;
    assign write_en  = ((state_reg == ST_LOAD_HDR) && !full[addr]) ||
                       (accept && ((state_reg == ST_LOAD_DATA) || (state_reg == ST_LOAD_PARITY)));
    assign push_data = (state_reg == ST_LOAD_HDR) ? hdr_reg : bus.data_in;
    // A flush of the port being written abandons the rest of the packet into DROP.
    assign target_flushed = flush[addr] &&
                            (state_reg inside {ST_LOAD_HDR, ST_LOAD_DATA, ST_LOAD_PARITY});

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign push[gi]  = write_en && (addr == ADDR_W'(gi));
        assign valid[gi] = !empty[gi];

        router_fifo #(
            .DEPTH(FIFO_DEPTH),
            .WIDTH(DATA_W)
        ) u_fifo (
            .clock (clock),
            .resetn(resetn),
            .flush (flush[gi]),
            .push  (push[gi]),
            .din   (push_data),
            .pop   (bus.read_enb[gi]),
            .dout  (dout[gi*DATA_W +: DATA_W]),
            .empty (empty[gi]),
            .full  (full[gi])
        );
    end

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_timeout
        logic [TW-1:0] idle_cnt_reg;

        assign flush[gi] = (idle_cnt_reg == TW'(TIMEOUT));

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                idle_cnt_reg <= '0;
            end else if (flush[gi] || !(valid[gi] && !bus.read_enb[gi])) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + TW'(1);
            end
        end
    end
`else
    assign flush = '0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            hdr_reg    <= '0;
            cnt_reg    <= '0;
            par_reg    <= '0;
            rx_par_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        hdr_reg   <= bus.data_in;
                        cnt_reg   <= DATA_W'(hdr_len(MAX_W'(bus.data_in), ADDR_W));
                        par_reg   <= bus.data_in;
                        error_reg <= 1'b0;
                        state_reg <= (hdr_addr(MAX_W'(bus.data_in), ADDR_W) >= MAX_W'(N_PORTS))
                                     ? ST_DROP : ST_LOAD_HDR;
                    end
                end
                ST_LOAD_HDR: begin
                    if (!full[addr]) begin
                        state_reg <= (cnt_reg == '0) ? ST_LOAD_PARITY : ST_LOAD_DATA;
                    end
                    if (target_flushed) state_reg <= ST_DROP;
                end
                ST_LOAD_DATA: begin
                    if (accept) begin
                        par_reg <= DATA_W'(parity_acc(MAX_W'(par_reg), MAX_W'(bus.data_in)));
                        cnt_reg <= cnt_reg - DATA_W'(1);
                        if (cnt_reg == DATA_W'(1)) state_reg <= ST_LOAD_PARITY;
                    end
                    if (target_flushed) state_reg <= ST_DROP;
                end
                ST_LOAD_PARITY: begin
                    if (accept) begin
                        rx_par_reg <= bus.data_in;
                        state_reg  <= ST_CHECK;
                    end else if (target_flushed) begin
                        state_reg <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    // Remaining payload is discarded but still folded into the parity.
                    if (accept) begin
                        if (cnt_reg == '0) begin
                            rx_par_reg <= bus.data_in;
                            state_reg  <= ST_CHECK;
                        end else begin
                            par_reg <= DATA_W'(parity_acc(MAX_W'(par_reg), MAX_W'(bus.data_in)));
                            cnt_reg <= cnt_reg - DATA_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    error_reg <= (rx_par_reg != par_reg);
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.error     = error_reg;
    assign bus.valid_out = valid;
    assign bus.data_out  = dout;
endmodule

// File: tb/tb_router_1xn.sv
// Self-checking bench for router_1xn: directed scenarios plus random packets against a queue model.
module tb_router_1xn;
    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TO  = 30;
`ifdef ROUTER_SOFT_RESET_EN
    localparam bit STALL_OK = 1'b0;
`else
    localparam bit STALL_OK = 1'b1;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   last_wait = 0;

    logic [7:0] exp_q [N][$];
    logic [7:0] pay_q [$];

    router_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

    router_1xn #(
        .N_PORTS(N), .DATA_W(DW), .FIFO_DEPTH(DEP), .TIMEOUT(TO)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial forever #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int waited;
        waited = 0;
        if (stall && $urandom_range(3) == 0) begin
            bus.pkt_valid = 1'b0;
            tick();
        end
        bus.pkt_valid = 1'b1;
        bus.data_in   = b;
        while (bus.busy !== 1'b0 && waited < 100) begin
            tick();
            waited++;
        end
        last_wait = waited;
        chk("accept_bound", waited < 100, 1);
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    // Header, pay_q payload, parity; the model derives addr/L from the header bits.
    task automatic send_packet(input logic [7:0] hdr, input bit stall, input bit force_par,
                               input logic [7:0] par_val, input bit pick_bad);
        int addr, len;
        logic [7:0] par, sent;
        bit was_empty;
        addr = hdr % 4;
        len  = hdr / 4;
        par  = hdr;
        was_empty = (addr < N) ? (exp_q[addr].size() == 0) : 1'b0;
        send_byte(hdr, stall);
        chk("err_clear", bus.error, 0);
        chk("busy_after_hdr", bus.busy, addr < N);
        if (addr < N) begin
            if (was_empty) chk("valid_before_write", bus.valid_out[addr], 0);
            exp_q[addr].push_back(hdr);
            tick();
            if (was_empty) chk("valid_after_write", bus.valid_out[addr], 1);
        end
        for (int i = 0; i < len; i++) begin
            par ^= pay_q[i];
            send_byte(pay_q[i], stall);
            if (addr < N) exp_q[addr].push_back(pay_q[i]);
        end
        if (force_par)     sent = par_val;
        else if (pick_bad) sent = par ^ 8'($urandom_range(255, 1));
        else               sent = par;
        send_byte(sent, stall);
        if (addr < N) exp_q[addr].push_back(sent);
        chk("busy_check", bus.busy, 1);
        tick();
        chk("error_flag", bus.error, sent != par);
        pay_q.delete();
    endtask

    task automatic drain(input int p);
        int guard;
        guard = 0;
        while (exp_q[p].size() > 0 && guard < 400) begin
            guard++;
            if ($urandom_range(3) == 0) begin
                tick();
                continue;
            end
            chk("valid_out", bus.valid_out[p], 1);
            chk("data_out", bus.data_out[p*8 +: 8], exp_q[p][0]);
            void'(exp_q[p].pop_front());
            bus.read_enb[p] = 1'b1;
            tick();
            bus.read_enb[p] = 1'b0;
        end
        chk("drain_left", exp_q[p].size(), 0);
        chk("empty_valid", bus.valid_out[p], 0);
        chk("empty_dout", bus.data_out[p*8 +: 8], 0);
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] b;
        int n;
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        bus.read_enb  = '0;

        // Reset
        #1 resetn = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_dout", bus.data_out, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Good packet to port 1
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("p1_len", exp_q[1].size(), 5);
        chk("p0_idle", bus.valid_out[0], 0);
        chk("p2_idle", bus.valid_out[2], 0);
        drain(1);

        // Bad parity: error set, held, then cleared by next header
        pay_q = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("error_held", bus.error, 1);
        drain(1);
        chk("error_held_after_drain", bus.error, 1);

        // Fill port 0 to depth and hold the parity byte on backpressure
        send_byte(8'h3C, 1'b0);
        chk("err_clear_full", bus.error, 0);
        exp_q[0].push_back(8'h3C);
        par = 8'h3C;
        for (int i = 0; i < 15; i++) begin
            b = 8'($urandom);
            par ^= b;
            send_byte(b, 1'b0);
            exp_q[0].push_back(b);
        end
        bus.pkt_valid = 1'b1;
        bus.data_in   = par;
        for (int i = 0; i < 4; i++) begin
            chk("busy_full", bus.busy, 1);
            tick();
        end
        chk("head_full", bus.data_out[7:0], 8'h3C);
        bus.read_enb[0] = 1'b1;
        tick();
        bus.read_enb[0] = 1'b0;
        void'(exp_q[0].pop_front());
        chk("busy_after_pop", bus.busy, 0);
        tick();
        bus.pkt_valid = 1'b0;
        exp_q[0].push_back(par);
        chk("busy_check_full", bus.busy, 1);
        tick();
        chk("error_full_pkt", bus.error, 0);
        drain(0);

        // Invalid address: discarded without stalling the source
        send_packet(8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop_wait", last_wait, 0);
        chk("drop_valid", bus.valid_out, 0);

        // Idle reader on port 2
        pay_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        send_packet(8'h0E, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef ROUTER_SOFT_RESET_EN
        n = 0;
        while (bus.valid_out[2] === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("flush_fell", bus.valid_out[2], 0);
        chk("flush_timing", (n >= TO - 5) && (n <= TO - 4), 1);
        chk("flush_dout", bus.data_out[23:16], 0);
        exp_q[2].delete();
`else
        n = 0;
        repeat (2 * TO) begin
            tick();
            n++;
        end
        chk("hold_valid", bus.valid_out[2], 1);
        chk("hold_cycles", n, 2 * TO);
        drain(2);
`endif

        // Random packets
        for (int k = 0; k < 25; k++) begin
            int a, l;
            a = $urandom_range(3);
            l = $urandom_range(13);
            for (int i = 0; i < l; i++) pay_q.push_back(8'($urandom));
            send_packet({l[5:0], a[1:0]}, STALL_OK, 1'b0, 8'h00, $urandom_range(3) == 0);
            for (int p = 0; p < N; p++) drain(p);
        end

        // Reset in the middle of a payload
        send_packet(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h11, 1'b0);
        chk("pre_reset_valid", bus.valid_out, 3'b011);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", bus.valid_out, 0);
        chk("async_rst_dout", bus.data_out, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_error", bus.error, 0);
        for (int p = 0; p < N; p++) exp_q[p].delete();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        pay_q = '{8'($urandom)};
        send_packet(8'h04, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_valid", bus.valid_out, 3'b001);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1);
    end
endmodule
